logic_unit_stage: RTL and testbench
===================================

// Module: logic_unit_stage
//
// PURPOSE
//   Registered 32-bit logic-op stage directly downstream of the gate-level bitwise blocks (AND32/OR32/XOR).
//   Accepts operand pairs plus an op select and produces one registered result per accepted transaction.
//   Also produces ARM-style N and Z flags for each result.
//   Valid/ready on both sides; a 2-entry skid buffer keeps full throughput under output backpressure.
//   Feeds the ALU result mux / writeback.
//
// PARAMETERS
//   WIDTH   32   operand/result width in bits; must be >= 2
//
// PORTS
//   clk         in   1      single clock, rising-edge
//   rst_n       in   1      asynchronous active-low reset
//   in_valid    in   1      upstream transaction valid
//   in_ready    out  1      stage can accept a transaction this cycle
//   in_a        in   WIDTH  operand A
//   in_b        in   WIDTH  operand B
//   in_op       in   2      00 AND, 01 ORR, 10 EOR, 11 BIC (A & ~B)
//   out_valid   out  1      result valid
//   out_ready   in   1      downstream accepts result
//   out_result  out  WIDTH  registered result
//   out_n       out  1      result[WIDTH-1]
//   out_z       out  1      1 iff result == 0
//
// BEHAVIOUR
// Reset and handshake
//   - Reset (async assert, sync deassert at clk edge): out_valid=0, out_result=0, out_n=0, out_z=0, both buffer entries empty.
//   - in_ready is 1 during and immediately after reset.
//   - Input handshake: accept when in_valid && in_ready. Output handshake: transfer when out_valid && out_ready.
//   - out_result/out_n/out_z must hold stable while out_valid && !out_ready.
//
// Datapath
//   - Result is computed combinationally from in_a/in_b/in_op with the gate-level bitwise blocks, then registered.
//   - No carry or overflow: C and V flags are not produced.
//
// Latency and throughput
//   - Latency: a transaction accepted at edge k is presented with out_valid=1 after edge k.
//   - Throughput is 1 per cycle while out_ready=1.
//
// Storage and state
//   - Storage is a main register (drives outputs) plus one skid register.
//   - States: EMPTY (main empty), ONE (main full, skid empty), FULL (both full).
//   - in_ready = (state != FULL); out_valid = (state != EMPTY). Both are registered, with no combinational path from out_ready.
//
// Transitions
//   EMPTY: accept -> ONE (main <= new).
//   ONE:   accept & take  -> ONE  (main <= new).
//          accept & !take -> FULL (skid <= new).
//          !accept & take -> EMPTY.
//   FULL:  take -> ONE (main <= skid). No accept is possible in FULL.
//
// Boundary rules
//   - Simultaneous accept and take in ONE is legal and keeps full rate.
//   - Transactions leave in accept order. None is dropped or duplicated.
//   - in_op and operands are sampled only on accept; values while !in_ready are ignored.
//   - Reset mid-operation discards all buffered results. No out_valid pulse follows reset.
//
// TESTING
//   - Reset: assert rst_n=0 mid-stream -> out_valid=0, out_result=0, out_z=0 immediately (async); in_ready=1.
//   - Ops, out_ready=1, A=FFFFFFFF B=00000000:
//       AND -> 0, z=1
//       ORR -> FFFFFFFF, n=1
//       EOR -> FFFFFFFF
//       BIC -> FFFFFFFF
//     Each result appears 1 cycle after accept.
//   - Exhaustive 1-bit truth table: run the 4 combinations of A[0]/B[0] with the other bits 0 for every op.
//     Result bit 0 must match the truth table; z=1 when bit 0 = 0.
//   - Backpressure: stream 4 EOR transactions (A=i, B=5) with out_ready=0.
//     in_ready drops after 2 accepts and the output holds 5 stable.
//     Release out_ready -> outputs 5, 4, then the remaining 2 in order, no loss.
//   - Full rate: in_valid=1 and out_ready=1 for 16 cycles -> 16 results on consecutive cycles, in_ready never 0.
//   - Random: random valid/ready/op for 10k cycles against a scoreboard queue.
//     No drop, no reordering, flags always consistent with the result.

Source files
------------

// File: rtl/logic_unit_stage.sv
// -----------------------------------------------------------------------------
// logic_unit_stage
//
// Registered bitwise logic stage (AND / ORR / EOR / BIC) with ARM-style N and Z
// flags. It sits after the bitwise gate blocks and feeds the ALU result mux.
// Both sides use valid/ready handshakes. A main register drives the outputs,
// and one skid register absorbs a single extra transaction, so out_ready never
// reaches in_ready combinationally and full rate holds under backpressure.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   in_valid    in   1      upstream transaction valid
//   in_ready    out  1      stage can accept a transaction this cycle (registered)
//   in_a        in   WIDTH  operand A
//   in_b        in   WIDTH  operand B
//   in_op       in   2      00 AND, 01 ORR, 10 EOR, 11 BIC (A & ~B)
//   out_valid   out  1      result valid (registered)
//   out_ready   in   1      downstream accepts result
//   out_result  out  WIDTH  registered result
//   out_n       out  1      result[WIDTH-1]
//   out_z       out  1      1 iff result == 0
// -----------------------------------------------------------------------------
module logic_unit_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_n,
    output logic             out_z
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_ORR = 2'b01;
    localparam logic [1:0] OP_EOR = 2'b10;
    localparam logic [1:0] OP_BIC = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    // Bitwise operation selected by op.
    function automatic logic [WIDTH-1:0] logic_op(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       op
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_ORR:  r = a | b;
            OP_EOR:  r = a ^ b;
            OP_BIC:  r = a & ~b;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Zero flag of a result word.
    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [WIDTH-1:0] main_result_r;
    logic             main_n_r;
    logic             main_z_r;
    logic [WIDTH-1:0] skid_result_r;
    logic             skid_n_r;
    logic             skid_z_r;

    logic [WIDTH-1:0] new_result_s;
    logic             new_n_s;
    logic             new_z_s;
    logic             accept_s;
    logic             take_s;
    logic             load_main_new_s;
    logic             load_main_skid_s;
    logic             load_skid_s;

    // Result and flags of the transaction currently offered upstream.
    always_comb begin
        new_result_s = logic_op(in_a, in_b, in_op);
        new_n_s      = new_result_s[WIDTH-1];
        new_z_s      = is_zero(new_result_s);
    end

    // Handshakes use only registered ready/valid, never out_ready -> in_ready.
    always_comb begin
        accept_s = in_valid && in_ready_r;
        take_s   = out_valid_r && out_ready;
    end

    // Next-state and register load selects for the main/skid pair.
    always_comb begin
        state_s          = state_r;
        load_main_new_s  = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_s         = ST_ONE;
                    load_main_new_s = 1'b1;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && take_s) begin
                    state_s         = ST_ONE;
                    load_main_new_s = 1'b1;
                end else if (accept_s) begin
                    state_s     = ST_FULL;
                    load_skid_s = 1'b1;
                end else if (take_s) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_ONE;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a take can happen.
                if (take_s) begin
                    state_s          = ST_ONE;
                    load_main_skid_s = 1'b1;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a clean empty stage.
                state_s = ST_EMPTY;
            end
        endcase
    end

    // State register plus registered in_ready/out_valid decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s != ST_FULL);
            out_valid_r <= (state_s != ST_EMPTY);
        end
    end

    // Main register: drives the outputs, holds while not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_result_r <= {WIDTH{1'b0}};
            main_n_r      <= 1'b0;
            main_z_r      <= 1'b0;
        end else if (load_main_new_s) begin
            main_result_r <= new_result_s;
            main_n_r      <= new_n_s;
            main_z_r      <= new_z_s;
        end else if (load_main_skid_s) begin
            main_result_r <= skid_result_r;
            main_n_r      <= skid_n_r;
            main_z_r      <= skid_z_r;
        end
    end

    // Skid register: catches the one transaction accepted while main is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_result_r <= {WIDTH{1'b0}};
            skid_n_r      <= 1'b0;
            skid_z_r      <= 1'b0;
        end else if (load_skid_s) begin
            skid_result_r <= new_result_s;
            skid_n_r      <= new_n_s;
            skid_z_r      <= new_z_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = main_result_r;
    assign out_n      = main_n_r;
    assign out_z      = main_z_r;

endmodule

// File: tb/tb_logic_unit_stage.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_stage
//
// Self-checking bench for logic_unit_stage. A monitor on the falling edge
// pushes an expected result whenever an input handshake is about to happen,
// and pops/compares one whenever an output handshake is about to happen.
// Scenario tasks drive stimulus 1 time unit after the rising edge and add
// their own directed checks.
// -----------------------------------------------------------------------------
module tb_logic_unit_stage;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] r;
        logic         n;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [1:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_n;
    logic         out_z;

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t push_e;
    int   checks = 0;
    int   errors = 0;

    logic_unit_stage #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_n      (out_n),
        .out_z      (out_z)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a & ~b;
        endcase
    endfunction

    // Scoreboard monitor: pop/compare first, then push the newly accepted item.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (out_valid) begin
                checks++;
                if (out_n !== out_result[W-1] || out_z !== (out_result == '0)) begin
                    errors++;
                    $display("FAIL flags: result=%h n=%b z=%b", out_result, out_n, out_z);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got result=%h with nothing expected", out_result);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (out_result !== mon_e.r || out_n !== mon_e.n || out_z !== mon_e.z) begin
                        errors++;
                        $display("FAIL sb_data: got r=%h n=%b z=%b expected r=%h n=%b z=%b",
                                 out_result, out_n, out_z, mon_e.r, mon_e.n, mon_e.z);
                    end
                end
            end
            if (in_valid && in_ready) begin
                push_e.r = model_op(in_a, in_b, in_op);
                push_e.n = push_e.r[W-1];
                push_e.z = (push_e.r == '0);
                sb_q.push_back(push_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = 2'b00;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_n !== 1'b0 ||
            out_z !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: v=%b r=%h n=%b z=%b rdy=%b expected v=0 r=0 n=0 z=0 rdy=1",
                     out_valid, out_result, out_n, out_z, in_ready);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_ops();
        logic [W-1:0] exp_r;
        logic         exp_n;
        logic         exp_z;
        out_ready = 1'b1;
        for (int op = 0; op < 4; op++) begin
            case (op)
                0:       begin exp_r = 32'h0000_0000; exp_n = 1'b0; exp_z = 1'b1; end
                default: begin exp_r = 32'hFFFF_FFFF; exp_n = 1'b1; exp_z = 1'b0; end
            endcase
            in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'h0; in_op = 2'(op);
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp_r || out_n !== exp_n || out_z !== exp_z) begin
                errors++;
                $display("FAIL op_%0d: v=%b r=%h n=%b z=%b expected v=1 r=%h n=%b z=%b",
                         op, out_valid, out_result, out_n, out_z, exp_r, exp_n, exp_z);
            end
            tick();
        end
    endtask

    task automatic test_truth_table();
        logic [3:0] tt[4];
        logic [3:0] row;
        logic       exp_bit;
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0100;
        out_ready = 1'b1;
        for (int op = 0; op < 4; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                row     = tt[op];
                exp_bit = row[ab];
                in_valid = 1'b1;
                in_a = {31'd0, ab[1]}; in_b = {31'd0, ab[0]}; in_op = 2'(op);
                tick();
                in_valid = 1'b0;
                checks++;
                if (out_valid !== 1'b1 || out_result[0] !== exp_bit ||
                    out_result[W-1:1] !== 31'd0 || out_z !== ~exp_bit) begin
                    errors++;
                    $display("FAIL truth_op%0d_ab%0d: v=%b r=%h z=%b expected bit0=%b z=%b",
                             op, ab, out_valid, out_result, out_z, exp_bit, ~exp_bit);
                end
                tick();
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_b = 32'd5; in_op = 2'b10; in_a = 32'd0;
        tick();
        in_a = 32'd1;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd5 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: v=%b r=%h rdy=%b expected v=1 r=5 rdy=1",
                     out_valid, out_result, in_ready);
        end
        tick();
        in_a = 32'd2;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd5) begin
                errors++;
                $display("FAIL bp_hold_%0d: rdy=%b v=%b r=%h expected rdy=0 v=1 r=5",
                         i, in_ready, out_valid, out_result);
            end
            if (i < 3) tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_result !== 32'd4 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: r=%h v=%b expected r=4 v=1", out_result, out_valid);
        end
        tick();
        in_a = 32'd3;
        checks++;
        if (out_result !== 32'd7 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_third: r=%h v=%b expected r=7 v=1", out_result, out_valid);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_result !== 32'd6 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_fourth: r=%h v=%b expected r=6 v=1", out_result, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_full_rate();
        int got;
        got = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL fr_ready_%0d: rdy=%b expected 1", i, in_ready);
            end
            if (out_valid === 1'b1) got++;
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_op = 2'($urandom_range(0, 3));
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid === 1'b1) got++;
            tick();
        end
        checks++;
        if (got !== 16) begin
            errors++;
            $display("FAIL fr_count: got %0d results expected 16", got);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_a      = $urandom;
            in_b      = ($urandom_range(0, 7) == 0) ? in_a : $urandom;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        checks++;
        if (sb_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: %0d results left, v=%b expected 0 left v=0",
                     sb_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'h0; in_op = 2'b01;
        repeat (3) tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_full: v=%b rdy=%b expected v=1 rdy=0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_z !== 1'b0 ||
            out_n !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: v=%b r=%h n=%b z=%b rdy=%b expected v=0 r=0 n=0 z=0 rdy=1",
                     out_valid, out_result, out_n, out_z, in_ready);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_pulse_%0d: v=%b expected 0", i, out_valid);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ops();
        test_truth_table();
        test_backpressure();
        test_full_rate();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
